// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from imem
// and hands {inst, pc} to decode; redirects squash any in-flight response.
module ysyx_22040237_ifu #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_en_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              imem_err_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_fault_o
);

    localparam logic [31:0]       NOP     = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_r, pc_d;
    logic [ADDR_W-1:0] redir_pc_r, redir_pc_d;
    logic              kill_r, kill_d;
    logic              accept;
    logic [ADDR_W-1:0] target;

    assign target = redirect_pc_i & ~ADDR_W'(3);

    // Next-state logic. In REQ, kill_r=1 only while a redirect waits for the
    // current (stale) request to be granted, so it doubles as the pending flag.
    always_comb begin
        state_d    = state;
        pc_d       = pc_r;
        kill_d     = kill_r;
        redir_pc_d = redir_pc_r;
        accept     = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_req_o && imem_gnt_i) begin
                    state_d = S_WAIT;
                    if (redirect_en_i) begin
                        pc_d   = target;
                        kill_d = 1'b1;
                    end else if (kill_r) begin
                        pc_d = redir_pc_r;
                    end
                end else if (redirect_en_i) begin
                    if (imem_req_o) begin
                        kill_d     = 1'b1;
                        redir_pc_d = target;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_r || redirect_en_i) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                        if (redirect_en_i) begin
                            pc_d = target;
                        end
                    end else begin
                        state_d = S_HOLD;
                        accept  = 1'b1;
                    end
                end else if (redirect_en_i) begin
                    kill_d = 1'b1;
                    pc_d   = target;
                end
            end
            S_HOLD: begin
                if (redirect_en_i) begin
                    state_d = S_REQ;
                    pc_d    = target;
                end else if (inst_ready_i) begin
                    state_d = S_REQ;
                    pc_d    = pc_r + PC_STEP;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // State and registered outputs; outputs are derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc_r         <= RESET_PC;
            kill_r       <= 1'b0;
            redir_pc_r   <= RESET_PC;
            imem_req_o   <= 1'b0;
            imem_addr_o  <= RESET_PC;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            pc_o         <= '0;
            inst_fault_o <= 1'b0;
        end else begin
            state        <= state_d;
            pc_r         <= pc_d;
            kill_r       <= kill_d;
            redir_pc_r   <= redir_pc_d;
            imem_req_o   <= (state_d == S_REQ);
            imem_addr_o  <= pc_d;
            inst_valid_o <= (state_d == S_HOLD);
            if (accept) begin
                inst_o       <= imem_err_i ? NOP : imem_rdata_i;
                pc_o         <= pc_r;
                inst_fault_o <= imem_err_i;
            end
        end
    end

`ifndef SYNTHESIS
    rvalid_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> (state == S_WAIT));
`endif

endmodule
